// File: rtl/pe_array_pkg.sv
// Shared types and sizing helpers for the PE-array scheduler.
package pe_array_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        FIN
    } sched_state_e;

    // Cycles needed for the last vector to ripple through all rows and columns.
    function automatic int unsigned drain_len(input int unsigned rows, input int unsigned cols);
        return rows + cols - 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned rows, input int unsigned cols,
                                              input int unsigned cnt_w);
        longint unsigned lim;
        longint unsigned vmax;
        int unsigned w;
        lim  = longint'(rows) + longint'(cols);
        vmax = (64'd1 << cnt_w) - 64'd1;
        if (vmax > lim) lim = vmax;
        w = 1;
        while ((64'd1 << w) <= lim) w++;
        return w;
    endfunction

endpackage

// File: rtl/pe_valid_pipe.sv
// psum_valid delay line: one stage per PE row, advancing only when the array is enabled.
module pe_valid_pipe #(
    parameter int unsigned DEPTH = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic en,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sr <= '0;
        end else if (en) begin
            sr[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1] & en;

endmodule

// File: rtl/pe_array_sched.sv
// Job scheduler for a systolic PE array: weight load, activation stream, drain, done.
// Optional macro PE_SCHED_WEIGHT_REUSE_EN adds keep_w to skip the weight load.
module pe_array_sched
    import pe_array_pkg::*;
#(
    parameter int unsigned NUM_PE   = 16,
    parameter int unsigned NUM_ROWS = 16,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             act_valid,
`ifdef PE_SCHED_WEIGHT_REUSE_EN
    input  logic             keep_w,
`endif
    output logic             busy,
    output logic             done,
    output logic             EN,
    output logic             W_EN,
    output logic             wt_rd,
    output logic             act_rd,
    output logic             psum_valid
);

    localparam int unsigned      CW         = cnt_width(NUM_ROWS, NUM_PE, CNT_W);
    localparam logic [CW-1:0]    LOAD_LAST  = CW'(NUM_ROWS - 1);
    localparam logic [CW-1:0]    DRAIN_LAST = CW'(drain_len(NUM_ROWS, NUM_PE) - 1);

    sched_state_e     state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [CNT_W-1:0] nv_q;
    logic             skip_load;
    logic             vec_last;

`ifdef PE_SCHED_WEIGHT_REUSE_EN
    assign skip_load = keep_w;
`else
    assign skip_load = 1'b0;
`endif

    assign vec_last = (cnt == (CW'(nv_q) - CW'(1)));

    // One counter serves all phases; it restarts from zero on every state change.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + CW'(1);
        busy     = (state != IDLE);
        done     = 1'b0;
        EN       = 1'b0;
        W_EN     = 1'b0;
        wt_rd    = 1'b0;
        act_rd   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (skip_load) state_nx = (num_vec == '0) ? FIN : STREAM;
                    else           state_nx = LOAD_W;
                end
            end
            LOAD_W: begin
                W_EN  = 1'b1;
                wt_rd = 1'b1;
                if (cnt == LOAD_LAST) state_nx = (nv_q == '0) ? FIN : STREAM;
            end
            STREAM: begin
                EN     = act_valid;
                act_rd = act_valid;
                cnt_nx = cnt + {{(CW-1){1'b0}}, act_valid};
                if (act_valid && vec_last) state_nx = DRAIN;
            end
            DRAIN: begin
                EN = 1'b1;
                if (cnt == DRAIN_LAST) state_nx = FIN;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (state_nx != state || state == IDLE) cnt_nx = '0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
            nv_q  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && start) nv_q <= num_vec;
        end
    end

    pe_valid_pipe #(
        .DEPTH(NUM_ROWS)
    ) u_valid_pipe (
        .CLK  (CLK),
        .RESET(RESET),
        .en   (EN),
        .din  (act_rd),
        .dout (psum_valid)
    );

endmodule

// File: tb/tb_pe_array_sched.sv
// Self-checking bench for pe_array_sched (NUM_PE=4, NUM_ROWS=4): job table plus reset corner cases.
module tb_pe_array_sched;

    localparam int unsigned NP = 4;
    localparam int unsigned NR = 4;
    localparam int unsigned CW = 16;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          start;
    logic [CW-1:0] num_vec;
    logic          act_valid;
`ifdef PE_SCHED_WEIGHT_REUSE_EN
    logic          keep_w;
`endif
    logic busy, done, EN, W_EN, wt_rd, act_rd, psum_valid;

    always #5 CLK = ~CLK;

    pe_array_sched #(
        .NUM_PE  (NP),
        .NUM_ROWS(NR),
        .CNT_W   (CW)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .num_vec   (num_vec),
        .act_valid (act_valid),
`ifdef PE_SCHED_WEIGHT_REUSE_EN
        .keep_w    (keep_w),
`endif
        .busy      (busy),
        .done      (done),
        .EN        (EN),
        .W_EN      (W_EN),
        .wt_rd     (wt_rd),
        .act_rd    (act_rd),
        .psum_valid(psum_valid)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int               nv;
        int unsigned      stall;     // bit k set: act_valid low on k-th STREAM cycle
        bit               keep;
        longint unsigned  start_xtra; // bit c set: extra start pulse at cycle c
        int               wen;
        int               act;
        int               psum;
        int               drain;
        int               done_at;
    } job_t;

    job_t jobs[$];

    function automatic int outs_vec();
        return {busy, done, EN, W_EN, wt_rd, act_rd, psum_valid};
    endfunction

    task automatic run_job(input job_t j, input string tag);
        int q[$];
        int en_idx = 0, wen = 0, wtr = 0, act = 0, psum = 0, drain = 0;
        int done_at = -1, done_cnt = 0, overlap = 0;
        int stream0;
        bit stalled;
        stream0 = j.keep ? 1 : 1 + NR;
        for (int c = 0; c < 200; c++) begin
            @(negedge CLK);
            start   = (c == 0) || (c < 64 && j.start_xtra[c]);
            num_vec = CW'(j.nv);
`ifdef PE_SCHED_WEIGHT_REUSE_EN
            keep_w  = j.keep;
`endif
            stalled   = (c >= stream0) && (c - stream0 < 32) && j.stall[c - stream0];
            act_valid = !stalled;
            #1;
            if (W_EN) wen++;
            if (wt_rd) wtr++;
            if (W_EN && EN) overlap++;
            if (stalled) chk({tag, "_stall_en"}, EN, 0);
            if (EN) begin
                if (act_rd) begin
                    act++;
                    q.push_back(en_idx + NR);
                end else begin
                    drain++;
                end
                if (psum_valid) begin
                    psum++;
                    if (q.size() == 0) chk({tag, "_psum_extra"}, 1, 0);
                    else               chk({tag, "_psum_at"}, en_idx, q.pop_front());
                end
                en_idx++;
            end else if (psum_valid) begin
                chk({tag, "_psum_no_en"}, 1, 0);
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (done_at >= 0 && c >= done_at + 2) break;
        end
        start = 1'b0;
        if (done_at < 0) chk({tag, "_done_timeout"}, 0, 1);
        chk({tag, "_wen"},      wen,      j.wen);
        chk({tag, "_wt_rd"},    wtr,      j.wen);
        chk({tag, "_act_rd"},   act,      j.act);
        chk({tag, "_psum"},     psum,     j.psum);
        chk({tag, "_drain"},    drain,    j.drain);
        chk({tag, "_done_at"},  done_at,  j.done_at);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_overlap"},  overlap,  0);
        chk({tag, "_sb_left"},  q.size(), 0);
        chk({tag, "_idle"},     busy,     0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; start = 1'b0; act_valid = 1'b0; num_vec = '0;
`ifdef PE_SCHED_WEIGHT_REUSE_EN
        keep_w = 1'b0;
`endif
        jobs.push_back('{3, 0,     1'b0, 64'd0,                    4, 3, 3, 7, 15});
        jobs.push_back('{0, 0,     1'b0, 64'd0,                    4, 0, 0, 0, 5});
        jobs.push_back('{5, 'hA,   1'b0, 64'd0,                    4, 5, 5, 7, 19});
        jobs.push_back('{1, 0,     1'b0, 64'd0,                    4, 1, 1, 7, 13});
        jobs.push_back('{3, 0,     1'b0, (64'd1 << 6) | (64'd1 << 15), 4, 3, 3, 7, 15});
`ifdef PE_SCHED_WEIGHT_REUSE_EN
        jobs.push_back('{2, 0,     1'b1, 64'd0,                    0, 2, 2, 7, 10});
        jobs.push_back('{0, 0,     1'b1, 64'd0,                    0, 0, 0, 0, 1});
`endif

        repeat (3) @(negedge CLK);
        #1;
        chk("reset_outs", outs_vec(), 0);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("post_reset_outs", outs_vec(), 0);

        foreach (jobs[i]) run_job(jobs[i], $sformatf("job%0d", i));

        // Reset in the third DRAIN cycle of a 3-vector job.
        @(negedge CLK);
        start = 1'b1; num_vec = CW'(3); act_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            start = 1'b0;
        end
        #1;
        chk("rst_in_drain", {EN, act_rd}, 2'b10);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        chk("rst_mid_outs", outs_vec(), 0);
        begin
            int dn = 0;
            for (int c = 0; c < 20; c++) begin
                @(negedge CLK);
                #1;
                if (done || busy) dn++;
            end
            chk("rst_mid_quiet", dn, 0);
        end
        run_job(jobs[0], "after_rst");

        // Start coinciding with reset must be ignored.
        @(negedge CLK);
        RESET = 1'b1; start = 1'b1; num_vec = CW'(2);
        @(negedge CLK);
        RESET = 1'b0; start = 1'b0;
        #1;
        chk("rst_start_busy", busy, 0);
        @(negedge CLK);
        #1;
        chk("rst_start_idle", outs_vec(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
